// File: rtl/c3lib_bitsync_filt.sv
// c3lib_bitsync_filt: per-bit synchronizer with a stability glitch filter and edge pulses.
module c3lib_bitsync_filt #(
    parameter int                DWIDTH      = 1,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DWIDTH-1:0] RESET_VAL   = '0,
    parameter int                FILT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] data_in,
    output logic [DWIDTH-1:0] data_out,
    output logic [DWIDTH-1:0] rise_pls,
    output logic [DWIDTH-1:0] fall_pls
);
    localparam int CW = (FILT_CYCLES < 1) ? 1 : $clog2(FILT_CYCLES + 1);
    localparam logic [CW-1:0] FMAX = CW'(FILT_CYCLES);
    if (DWIDTH < 1 || DWIDTH > 64) begin : g_bad_dwidth
        $error("c3lib_bitsync_filt: DWIDTH out of range 1..64");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("c3lib_bitsync_filt: SYNC_STAGES out of range 2..4");
    end
    if (FILT_CYCLES < 0 || FILT_CYCLES > 255) begin : g_bad_filt
        $error("c3lib_bitsync_filt: FILT_CYCLES out of range 0..255");
    end
    for (genvar i = 0; i < DWIDTH; i++) begin : g_bit
        logic [SYNC_STAGES-1:0] sh;
        logic [CW-1:0]          cnt;
        logic                   q, r, f, s, mis, done;
        assign s    = sh[SYNC_STAGES-1];
        assign mis  = s != q;
        // the output only moves once the mismatch has persisted FILT_CYCLES+1 edges
        assign done = mis && cnt == FMAX;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sh  <= {SYNC_STAGES{RESET_VAL[i]}};
                cnt <= '0;
                q   <= RESET_VAL[i];
                r   <= 1'b0;
                f   <= 1'b0;
            end else begin
                sh  <= {sh[SYNC_STAGES-2:0], data_in[i]};
                cnt <= (mis && !done) ? cnt + 1'b1 : '0;
                q   <= done ? s : q;
                r   <= done & s;
                f   <= done & ~s;
            end
        end
        assign data_out[i] = q;
        assign rise_pls[i] = r;
        assign fall_pls[i] = f;
    end
endmodule
